// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: captures AES ciphertext blocks on the rising edge of the
// encryptor's valid flag, buffers up to DEPTH of them, and streams them out
// byte by byte (MSB byte first) over a valid/ready handshake.
//
// Handshake: out_valid is high whenever at least one block is buffered and
// does not depend on out_ready. A byte transfers on every clk edge where
// out_valid & out_ready are both high. While out_valid=1 and out_ready=0,
// out_data/out_idx/out_last hold. out_ready has no effect while out_valid=0.
module aes_ct_serializer #(
  parameter int DEPTH  = 2,
  parameter int NBYTES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [127:0]               ct,
  input  logic                       ct_valid,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [3:0]                 out_idx,
  output logic [$clog2(DEPTH):0]     blk_count,
  output logic                       overrun,
  input  logic                       clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             ct_valid_q;
  logic [127:0]     mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [3:0]       idx_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;

  logic             cap;
  logic             xfer;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;
  logic             last_byte;
  logic [127:0]     head;
  logic [6:0]       bit_lo;

  assign cap       = ct_valid & ~ct_valid_q;
  assign out_valid = (cnt_q != '0);
  assign last_byte = (idx_q == 4'(NBYTES - 1));
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & last_byte;
  assign full      = (cnt_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a capture at full still fits.
  assign wr_en     = cap & (~full | pop);
  assign drop      = cap & full & ~pop;

  // Byte 0 is ct[127:120]; byte NBYTES-1 is ct[7:0].
  assign head      = mem_q[rd_ptr_q];
  assign bit_lo    = 7'((NBYTES - 1 - int'(idx_q)) * 8);
  assign out_data  = out_valid ? head[bit_lo +: 8] : 8'h00;
  assign out_last  = out_valid & last_byte;
  assign out_idx   = idx_q;
  assign blk_count = cnt_q;
  assign overrun   = ovf_q;

  // Edge-detect register; resets high so a level already high at reset
  // release must drop before it can trigger a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_valid_q <= 1'b1;
    end else begin
      ct_valid_q <= ct_valid;
    end
  end

  // Block storage; contents are only visible through out_data when counted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= ct;
    end
  end

  // Pointers, byte index, occupancy and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (xfer) begin
        idx_q <= pop ? 4'd0 : idx_q + 4'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule
